// File: rtl/operand_hazard_unit_pkg.sv
// Shared constants for decode-stage operand control: opcodes, in-flight entry
// layout and forward-select encoding.
package operand_hazard_unit_pkg;

    localparam int REG_W  = 5;
    localparam int OPC_W  = 7;
    localparam int FWD_RF = 0;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             rwe;
        logic             is_load;
    } entry_t;

endpackage

// File: rtl/operand_fwd_match.sv
// Per-port priority search over in-flight stages: the youngest matching
// producer wins and either forwards its stage index or raises a hazard.
import operand_hazard_unit_pkg::*;

module operand_fwd_match #(
    parameter int DEPTH      = 2,
    parameter int LOAD_READY = 2,
    parameter int SELW       = $clog2(DEPTH + 1)
) (
    input  entry_t [DEPTH-1:0] entries,
    input  logic [REG_W-1:0]   rs,
    input  logic               rs_use,
    output logic [SELW-1:0]    fwd_sel,
    output logic               hazard
);

    logic [DEPTH-1:0] match;
    logic [DEPTH-1:0] ready;

    // entries[gi] is stage gi+1; x0 is hard-wired so it is never a producer
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        assign match[gi] = entries[gi].valid && entries[gi].rwe &&
                           (entries[gi].rd != '0) && (entries[gi].rd == rs) && rs_use;
        assign ready[gi] = !entries[gi].is_load || ((gi + 1) >= LOAD_READY);
    end

    // Scan oldest to youngest so the youngest match has the final word
    always_comb begin
        fwd_sel = SELW'(FWD_RF);
        hazard  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[k]) begin
                fwd_sel = ready[k] ? SELW'(k + 1) : SELW'(FWD_RF);
                hazard  = !ready[k];
            end
        end
    end

endmodule

// File: rtl/operand_hazard_unit.sv
// Decode-stage forwarding select, load-use stall and ALU operand select decode.
// Optional stall-cycle counter on stall_cnt when FWD_STALL_CNT_EN is defined.
import operand_hazard_unit_pkg::*;

module operand_hazard_unit #(
    parameter int NREAD      = 2,
    parameter int DEPTH      = 2,
    parameter int LOAD_READY = 2,
    parameter int SELW       = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic [OPC_W-1:0]        opcode,
    input  logic [NREAD*REG_W-1:0]  rs_idx,
    input  logic [NREAD-1:0]        rs_use,
    input  logic [REG_W-1:0]        rd,
    input  logic                    rwe,
    input  logic                    flush,
    output logic [NREAD*SELW-1:0]   fwd_sel,
    output logic                    stall,
    output logic                    sel_a,
    output logic                    sel_b
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);

    entry_t [DEPTH-1:0] stage_reg;
    entry_t             issue_entry;
    logic [NREAD-1:0]   hazard;

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_port
        operand_fwd_match #(
            .DEPTH      (DEPTH),
            .LOAD_READY (LOAD_READY),
            .SELW       (SELW)
        ) u_match (
            .entries (stage_reg),
            .rs      (rs_idx[REG_W*gi +: REG_W]),
            .rs_use  (rs_use[gi]),
            .fwd_sel (fwd_sel[SELW*gi +: SELW]),
            .hazard  (hazard[gi])
        );
    end

    // A flush kills the decode instruction, so any hazard it sees is moot
    assign stall = issue_valid && !flush && (|hazard);

    always_comb begin
        issue_entry.valid   = 1'b1;
        issue_entry.rd      = rd;
        issue_entry.rwe     = rwe;
        issue_entry.is_load = (opcode == OPC_LOAD);
    end

    // Downstream never stalls; flush discards the instruction leaving stage 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg[0] <= (issue_valid && !stall && !flush) ? issue_entry : '0;
            for (int k = 1; k < DEPTH; k++) begin
                stage_reg[k] <= (k == 1 && flush) ? '0 : stage_reg[k-1];
            end
        end
    end

    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR, OPC_LUI: sel_b = 1'b1;
            OPC_JAL, OPC_BRANCH, OPC_AUIPC: begin
                sel_a = 1'b1;
                sel_b = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/operand_hazard_unit.md
# operand_hazard_unit

Decode-stage operand control for the pipelined core, generalising single-stage writeback forwarding to NREAD source ports and DEPTH in-flight stages. It keeps a shift register of in-flight destination writes and picks, per source port, the youngest forwardable producer. It asserts a stall when the youngest producer is a load whose data is not yet available, and inserts a bubble. It also decodes the ALU A/B operand selects from the opcode.

## Interface
Parameters:
- NREAD, 2: number of source-register ports.
- DEPTH, 2: number of tracked stages after decode (stage 1 = youngest).
- LOAD_READY, 2: first stage index at which load data is forwardable; 1 ≤ LOAD_READY ≤ DEPTH.
- SELW, $clog2(DEPTH+1): width of each forward select.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- issue_valid  in  1  decode holds a valid instruction.
- opcode  in  7  decode opcode.
- rs_idx  in  NREAD*5  source indices, port p at [5p+4:5p].
- rs_use  in  NREAD  port p actually reads its register.
- rd  in  5  decode destination.
- rwe  in  1  decode writes rd.
- flush  in  1  kill decode instruction and stage 1 (taken branch/jump).
- fwd_sel  out  NREAD*SELW  per port: 0 = regfile, k = stage k data.
- stall  out  1  hold PC/decode, insert bubble.
- sel_a  out  1  1 = PC, 0 = rs1 data.
- sel_b  out  1  1 = immediate, 0 = rs2 data.
- stall_cnt  out  32  stall-cycle count (only with FWD_STALL_CNT_EN).

## Operation
- Entry per stage: {valid, rd, rwe, is_load}. is_load = (opcode == OPC_LOAD).
- Port p matches stage k when: valid_k, rwe_k, rd_k != 0, rd_k == rs_p, and rs_use[p].
- Youngest (lowest k) match wins. Index 0 never matches, so its select is 0.
- Ready: !is_load_k or k ≥ LOAD_READY.
- Youngest match ready: fwd_sel_p = k. Not ready: hazard_p. No match: fwd_sel_p = 0.
- stall = issue_valid & !flush & OR(hazard_p).
- Entry update on each posedge:
  - Stage k>1 takes stage k-1 unconditionally. Downstream never stalls.
  - Stage 1 takes {1, rd, rwe, is_load} when issue_valid & !stall & !flush; otherwise it takes a bubble (valid = 0).
  - flush also loads a bubble into stage 2, discarding the current stage 1.
- sel_a/sel_b decode:
  - R-type: 0/0.
  - I-type, LOAD, STORE, JALR, LUI: 0/1.
  - JAL, BRANCH, AUIPC: 1/1.
  - Default: 0/0.
  - The decode is independent of stall.

## Timing
- fwd_sel, stall, sel_a, sel_b are combinational from inputs and registered entries (0 register latency).
- An instruction issued in cycle t occupies stage k during cycle t+k.
- A load followed by a dependent instruction stalls LOAD_READY-1 cycles. With the defaults this is 1 stall cycle, then fwd_sel = 2.
- Reset: all entries invalid, stall_cnt = 0. With no entries valid, outputs are fwd_sel = 0 and stall = 0. sel_a/sel_b follow the opcode.
- Reset mid-stall: stall drops in the same cycle, asynchronously.
- Simultaneous flush and hazard: flush wins, stall = 0, and a bubble is inserted.
- Same rd in stage 1 and stage 2: stage 1 is selected, even when stage 1 is an unready load. In that case the port stalls.

## Configuration
- FWD_STALL_CNT_EN defined: a 32-bit counter increments on every cycle with stall = 1. It saturates at 0xFFFFFFFF and clears on rst. The counter is exposed on stall_cnt.
- FWD_STALL_CNT_EN undefined: the port and the counter are absent.

## Structure
- Opcode constants (OPC_*) come from the shared Opcode.vh header.
- Entry field widths and fwd_sel encoding constants (FWD_RF = 0) belong in a shared header, operand_hazard.vh.
- Sub-module operand_fwd_match: one instance per port. It takes all entries and one rs/rs_use, and outputs fwd_sel and hazard via a priority search over stages 1..DEPTH.

## Test plan
- Reset, then issue add x3 (rd=3, rwe=1). Next cycle, issue rs_idx[0]=3 → fwd_sel[0]=1, stall=0. One cycle later rs=3 gives fwd_sel=2.
- lw x5, then a dependent add using rs_idx[1]=5 → stall=1 for 1 cycle, stage 1 bubble, then fwd_sel[1]=2, stall=0.
- Producer with rd=0, rwe=1, then consumer with rs=0 → fwd_sel=0, stall=0.
- lw x7 in decode with flush=1, then consumer with rs=7 → no stall and fwd_sel=0. Stage 2 also cleared.
- Opcodes JAL/LUI/R-type → sel_a/sel_b = 1/1, 0/1, 0/0 respectively.
- FWD_STALL_CNT_EN: three back-to-back load-use pairs → stall_cnt = 3. Assert rst → stall_cnt = 0 immediately.
